// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - fixed-latency single-port word memory behind the cache request port
// One request in flight; completion is a one-cycle ready pulse carrying read data.
module cache_mem_responder #(
   parameter int    ADDR_W    = 10,
   parameter int    LATENCY   = 4,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_req_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_req_valid,
   input  logic        mem_req_wr,
   output logic [31:0] mem_req_data,
   output logic        mem_req_ready,
   output logic        mem_busy,
   output logic        mem_addr_err
);

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [7:0]        cnt;
   logic [ADDR_W-1:0] idx;
   logic              wr;
   logic [31:0]       wr_data;
   logic              range_err;
   logic [31:0]       mem [DEPTH];

   generate
      if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
         $error("cache_mem_responder: LATENCY must be in 1..255");
      end
   endgenerate

   initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

   logic [ADDR_W-1:0] in_idx;
   logic              in_err;
   logic              unused_addr_lsb;
   assign in_idx          = mem_req_addr[ADDR_W+1:2];
   assign in_err          = |mem_req_addr[31:ADDR_W+2];
   assign unused_addr_lsb = ^mem_req_addr[1:0];

   // With LATENCY==1 the access happens on the accepting edge, so use the live request.
   logic              enter_resp;
   logic [ADDR_W-1:0] acc_idx;
   logic              acc_wr;
   logic [31:0]       acc_data;
   assign enter_resp = ((state == IDLE) && mem_req_valid && (LATENCY == 1))
                    || ((state == WAIT) && (cnt == 8'd1));
   assign acc_idx    = (state == IDLE) ? in_idx      : idx;
   assign acc_wr     = (state == IDLE) ? mem_req_wr  : wr;
   assign acc_data   = (state == IDLE) ? mem_wr_data : wr_data;

   always @(posedge clk) begin
      if (!rst && enter_resp && acc_wr)
         mem[acc_idx] <= acc_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         mem_req_ready <= 1'b0;
         mem_busy      <= 1'b0;
         mem_addr_err  <= 1'b0;
         mem_req_data  <= 32'd0;
      end else begin
         mem_req_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req_valid) begin
                  idx       <= in_idx;
                  wr        <= mem_req_wr;
                  wr_data   <= mem_wr_data;
                  range_err <= in_err;
                  cnt       <= CNT_INIT;
                  mem_busy  <= 1'b1;
                  if (LATENCY == 1) begin
                     state         <= RESP;
                     mem_req_ready <= 1'b1;
                     mem_addr_err  <= in_err;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) begin
                  state         <= RESP;
                  mem_req_ready <= 1'b1;
                  mem_addr_err  <= range_err;
               end
            end
            RESP: begin
               state        <= IDLE;
               mem_busy     <= 1'b0;
               mem_addr_err <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (enter_resp && !acc_wr)
            mem_req_data <= mem[acc_idx];
      end
   end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - randomized bench with a timing/memory model for two latency configurations
module tb_cache_mem_responder;

   localparam int ADDR_W = 10;
   localparam int LAT0   = 4;
   localparam int LAT1   = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic        m_valid [2];
   logic        m_wr    [2];
   logic [31:0] d_data  [2];
   logic        d_ready [2];
   logic        d_busy  [2];
   logic        d_err   [2];

   always #5 clk = ~clk;

   cache_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT0), .INIT_FILE("")) u_dut_lat4 (
      .clk(clk), .rst(rst),
      .mem_req_addr(m_addr[0]), .mem_wr_data(m_wdata[0]), .mem_req_valid(m_valid[0]), .mem_req_wr(m_wr[0]),
      .mem_req_data(d_data[0]), .mem_req_ready(d_ready[0]), .mem_busy(d_busy[0]), .mem_addr_err(d_err[0]));

   cache_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT1), .INIT_FILE("")) u_dut_lat1 (
      .clk(clk), .rst(rst),
      .mem_req_addr(m_addr[1]), .mem_wr_data(m_wdata[1]), .mem_req_valid(m_valid[1]), .mem_req_wr(m_wr[1]),
      .mem_req_data(d_data[1]), .mem_req_ready(d_ready[1]), .mem_busy(d_busy[1]), .mem_addr_err(d_err[1]));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // Model: one outstanding request per instance, completing LATENCY-1 cycles after the accepting edge.
   bit          pend     [2];
   int          acc      [2];
   bit          pwr      [2];
   logic [9:0]  pidx     [2];
   logic [31:0] pdata    [2];
   bit          perr     [2];
   logic [31:0] exp_data [2];
   logic [31:0] mdl_mem  [int];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int ch);
      return (ch == 0) ? LAT0 : LAT1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < 2; ch++) begin
         pend[ch]     = 1'b0;
         exp_data[ch] = 32'd0;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int ch = 0; ch < 2; ch++) begin
               int r;
               bit eb;
               bit er;
               int key;
               r   = acc[ch] + lat(ch) - 1;
               eb  = pend[ch] && (cyc >= acc[ch]) && (cyc <= r);
               er  = pend[ch] && (cyc == r);
               key = ch * 4096 + int'(pidx[ch]);
               if (er) begin
                  if (pwr[ch]) mdl_mem[key] = pdata[ch];
                  else exp_data[ch] = mdl_mem.exists(key) ? mdl_mem[key] : 32'd0;
                  pend[ch] = 1'b0;
               end
               check($sformatf("ready%0d", ch), 32'(d_ready[ch]), 32'(er));
               check($sformatf("busy%0d", ch),  32'(d_busy[ch]),  32'(eb));
               check($sformatf("err%0d", ch),   32'(d_err[ch]),   32'(er && perr[ch]));
               check($sformatf("data%0d", ch),  d_data[ch],       exp_data[ch]);
            end
         end
      end
   end

   // Issues one request starting in the current cycle; returns in the cycle after the ready cycle.
   task automatic do_req(input int ch, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input bit drop_early, input bit scramble,
                         output int acc_c, output int rdy_c, output int rdy_n,
                         output logic [31:0] rd, output logic re);
      int l;
      l     = lat(ch);
      acc_c = -1;
      rdy_c = -1;
      rdy_n = 0;
      rd    = '0;
      re    = 1'b0;
      m_valid[ch] = 1'b1;
      m_wr[ch]    = wr;
      m_addr[ch]  = a;
      m_wdata[ch] = d;
      if (d_ready[ch]) rdy_n++;
      for (int k = 0; k <= l; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            acc_c     = cyc;
            acc[ch]   = cyc;
            pwr[ch]   = wr;
            pidx[ch]  = a[ADDR_W+1:2];
            pdata[ch] = d;
            perr[ch]  = |a[31:ADDR_W+2];
            pend[ch]  = 1'b1;
            if (drop_early && l > 1) m_valid[ch] = 1'b0;
            if (scramble) begin
               m_addr[ch]  = $urandom;
               m_wdata[ch] = $urandom;
               m_wr[ch]    = 1'($urandom);
            end
         end
         if (k == l - 1) begin
            m_valid[ch] = 1'b0;
            rd = d_data[ch];
            re = d_err[ch];
         end
         if (d_ready[ch]) begin
            rdy_n++;
            if (rdy_c < 0) rdy_c = cyc;
         end
      end
   endtask

   task automatic rand_traffic(input int ch, input int n);
      int ac, rc, rn;
      logic [31:0] rd;
      logic re;
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         logic [19:0] hi;
         hi = ($urandom_range(0, 5) == 0) ? 20'($urandom) : 20'd0;
         a  = {hi, 10'(32 + $urandom_range(0, 7)), 2'($urandom)};
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         do_req(ch, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3) == 0,
                1'($urandom_range(0, 1)), ac, rc, rn, rd, re);
      end
   endtask

   initial begin
      int ac, rc, rn, rc_w;
      logic [31:0] rd;
      logic re;
      rst = 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
         m_valid[ch] = 1'b0;
         m_wr[ch]    = 1'b0;
         m_addr[ch]  = '0;
         m_wdata[ch] = '0;
         pend[ch]    = 1'b0;
         acc[ch]     = 0;
         pwr[ch]     = 1'b0;
         pidx[ch]    = '0;
         pdata[ch]   = '0;
         perr[ch]    = 1'b0;
      end
      model_reset();

      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
         check("reset_ready", 32'(d_ready[ch]), 32'd0);
         check("reset_busy",  32'(d_busy[ch]),  32'd0);
         check("reset_data",  d_data[ch],       32'd0);
         check("reset_err",   32'(d_err[ch]),   32'd0);
      end

      do_req(0, 1'b1, 32'h0000_0040, 32'hDEADBEEF, 1'b0, 1'b0, ac, rc, rn, rd, re);
      check("wr_latency", 32'(rc - ac), 32'd3);
      check("wr_pulses",  32'(rn), 32'd1);
      do_req(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, ac, rc, rn, rd, re);
      check("rd40_data", rd, 32'hDEADBEEF);
      check("rd40_err",  32'(re), 32'd0);
      do_req(0, 1'b0, 32'h0000_0041, 32'h0, 1'b0, 1'b1, ac, rc, rn, rd, re);
      check("rd41_data", rd, 32'hDEADBEEF);
      do_req(0, 1'b0, 32'h0000_1040, 32'h0, 1'b0, 1'b0, ac, rc, rn, rd, re);
      check("rd1040_data", rd, 32'hDEADBEEF);
      check("rd1040_err",  32'(re), 32'd1);

      do_req(0, 1'b1, 32'h0000_0080, 32'h11111111, 1'b0, 1'b0, ac, rc_w, rn, rd, re);
      do_req(0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 1'b0, ac, rc, rn, rd, re);
      check("wb_alloc_spacing", 32'(rc - rc_w), 32'd5);
      check("wb_alloc_data", rd, 32'h11111111);

      do_req(0, 1'b1, 32'h0000_0100, 32'h5A5A5A5A, 1'b0, 1'b0, ac, rc, rn, rd, re);
      m_valid[0] = 1'b1;
      m_wr[0]    = 1'b1;
      m_addr[0]  = 32'h0000_0100;
      m_wdata[0] = 32'h22222222;
      @(posedge clk);
      #1;
      acc[0] = cyc; pwr[0] = 1'b1; pidx[0] = 10'h040; pdata[0] = 32'h22222222; perr[0] = 1'b0;
      pend[0] = 1'b1;
      m_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      rn = 0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         model_reset();
         #1;
         if (d_ready[0]) rn++;
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (d_ready[0]) rn++;
      end
      check("abort_no_ready", 32'(rn), 32'd0);
      do_req(0, 1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0, ac, rc, rn, rd, re);
      check("abort_prior_data", rd, 32'h5A5A5A5A);

      do_req(1, 1'b1, 32'h0000_0040, 32'h12345678, 1'b0, 1'b0, ac, rc, rn, rd, re);
      do_req(1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, ac, rc, rn, rd, re);
      check("lat1_latency", 32'(rc - ac), 32'd0);
      check("lat1_pulses",  32'(rn), 32'd1);
      check("lat1_data",    rd, 32'h12345678);
      do_req(0, 1'b0, 32'h0000_0080, 32'h0, 1'b1, 1'b0, ac, rc, rn, rd, re);
      check("drop_pulses", 32'(rn), 32'd1);
      check("drop_data",   rd, 32'h11111111);

      fork
         rand_traffic(0, 60);
         rand_traffic(1, 90);
      join

      repeat (4) begin
         @(posedge clk);
         #1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
